// File: rtl/vram_arbiter_pkg.sv
// Shared definitions for the video RAM arbiter.
//   - default address/data widths and arbitration limits
//   - requester port identifiers (also used as read-return tags)
//   - base addresses of the frame buffer and the command area
//   - read-return tag carried down the two-stage return pipe
package vram_pkg;

  localparam int VRAM_AW         = 18;
  localparam int VRAM_DW         = 8;
  localparam int VRAM_SCAN_BURST = 4;
  localparam int VRAM_MAX_WAIT   = 6;

  localparam logic [17:0] VRAM_BUF_BASE = 18'h00000;
  localparam logic [17:0] VRAM_CMD_BASE = 18'h20000;

  typedef enum logic [1:0] {
    PORT_SCAN = 2'd0,
    PORT_VDC  = 2'd1,
    PORT_CPU  = 2'd2
  } port_e;

  typedef struct packed {
    logic  valid;
    port_e port;
  } tag_t;

endpackage

// File: rtl/vram_arbiter_if.sv
// Bus bundle between the three VRAM requesters, the arbiter and the RAM macro.
//   master : requester side plus the RAM macro (drives req/addr/we/wdata, mem_i)
//   slave  : arbiter side (drives ack/rvalid/rdata and mem_a/mem_o/mem_w)
//
// Handshake: a requester raises x_req together with x_addr (and x_we/x_wdata)
// and holds all of them stable until x_ack is seen high in the same cycle;
// x_ack is combinational, and the request is issued on that clock edge. The
// requester may present its next request in the following cycle. A read
// issued in cycle N is answered by x_rvalid in cycle N+2 with data on rdata.
interface vram_arbiter_if #(
  parameter int AW = 18,
  parameter int DW = 8
);
  logic          s_req;
  logic [AW-1:0] s_addr;
  logic          s_ack;
  logic          s_rvalid;

  logic          v_req;
  logic          v_we;
  logic [AW-1:0] v_addr;
  logic [DW-1:0] v_wdata;
  logic          v_ack;
  logic          v_rvalid;

  logic          c_req;
  logic          c_we;
  logic [AW-1:0] c_addr;
  logic [DW-1:0] c_wdata;
  logic          c_ack;
  logic          c_rvalid;

  logic [DW-1:0] rdata;

  logic [AW-1:0] mem_a;
  logic [DW-1:0] mem_o;
  logic          mem_w;
  logic [DW-1:0] mem_i;

  modport master (
    output s_req, s_addr,
    output v_req, v_we, v_addr, v_wdata,
    output c_req, c_we, c_addr, c_wdata,
    output mem_i,
    input  s_ack, s_rvalid, v_ack, v_rvalid, c_ack, c_rvalid, rdata,
    input  mem_a, mem_o, mem_w
  );

  modport slave (
    input  s_req, s_addr,
    input  v_req, v_we, v_addr, v_wdata,
    input  c_req, c_we, c_addr, c_wdata,
    input  mem_i,
    output s_ack, s_rvalid, v_ack, v_rvalid, c_ack, c_rvalid, rdata,
    output mem_a, mem_o, mem_w
  );

endinterface

// File: rtl/vram_arbiter_wait_cnt.sv
// Saturating wait counter for one requester.
//   clock, reset_n : clock and async active-low reset
//   inc            : count one more waiting cycle (ignored once saturated)
//   clr            : return to zero (wins over inc)
//   sat            : counter has reached MAX
module vram_wait_cnt #(
  parameter int MAX = 6
) (
  input  logic clock,
  input  logic reset_n,
  input  logic inc,
  input  logic clr,
  output logic sat
);

  localparam int CW = $clog2(MAX + 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  assign sat = (cnt_q == CW'(MAX));

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && !sat) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/vram_arbiter.sv
// Arbiter for the single-port video RAM shared by scanout, the vidac drawing
// engine and the CPU.
//   clock, reset_n : clock and async active-low reset
//   bus            : requester handshakes, read return and RAM macro signals
//   dbg_rr_last    : which of vidac/CPU won the last contested-class grant
// Scanout has priority but is capped at SCAN_BURST back-to-back grants while
// vidac or CPU is waiting. Between vidac and CPU, a port that has waited
// MAX_WAIT cycles goes first, otherwise they alternate.
module vram_arbiter
  import vram_pkg::*;
#(
  parameter int AW         = VRAM_AW,
  parameter int DW         = VRAM_DW,
  parameter int SCAN_BURST = VRAM_SCAN_BURST,
  parameter int MAX_WAIT   = VRAM_MAX_WAIT
) (
  input  logic  clock,
  input  logic  reset_n,
  vram_arbiter_if.slave bus,
  output port_e dbg_rr_last
);

  localparam int BW = $clog2(SCAN_BURST + 1);

  logic          s_ack;
  logic          v_ack;
  logic          c_ack;
  logic          vc_any;
  logic          scan_cap;
  logic          v_sat;
  logic          c_sat;
  logic          v_hot;
  logic          c_hot;
  logic          pick_v;

  logic [BW-1:0] burst_q, burst_d;
  port_e         rr_last_q, rr_last_d;
  logic [AW-1:0] mem_a_q, mem_a_d;
  logic [DW-1:0] mem_o_q, mem_o_d;
  logic          mem_w_q, mem_w_d;
  tag_t          tag1_q, tag1_d;
  tag_t          tag2_q, tag2_d;

  assign vc_any   = bus.v_req | bus.c_req;
  assign scan_cap = (burst_q == BW'(SCAN_BURST)) && vc_any;
  assign v_hot    = v_sat & bus.v_req;
  assign c_hot    = c_sat & bus.c_req;
  // When vidac and CPU tie, the one that did not win last time goes.
  assign pick_v   = (rr_last_q != PORT_VDC);

  // Grant selection; exactly one or zero acks per cycle.
  always_comb begin
    s_ack = 1'b0;
    v_ack = 1'b0;
    c_ack = 1'b0;
    if (bus.s_req && !scan_cap) begin
      s_ack = 1'b1;
    end else if (v_hot && c_hot) begin
      v_ack = pick_v;
      c_ack = !pick_v;
    end else if (v_hot) begin
      v_ack = 1'b1;
    end else if (c_hot) begin
      c_ack = 1'b1;
    end else if (bus.v_req && bus.c_req) begin
      v_ack = pick_v;
      c_ack = !pick_v;
    end else if (bus.v_req) begin
      v_ack = 1'b1;
    end else if (bus.c_req) begin
      c_ack = 1'b1;
    end
  end

  // Issue registers, tag pipe, burst counter and round-robin pointer.
  always_comb begin
    mem_a_d     = mem_a_q;
    mem_o_d     = mem_o_q;
    mem_w_d     = 1'b0;
    tag1_d      = '{valid: 1'b0, port: PORT_SCAN};
    tag2_d      = tag1_q;
    burst_d     = burst_q;
    rr_last_d   = rr_last_q;

    if (s_ack) begin
      mem_a_d = bus.s_addr;
      tag1_d  = '{valid: 1'b1, port: PORT_SCAN};
    end else if (v_ack) begin
      mem_a_d   = bus.v_addr;
      mem_o_d   = bus.v_wdata;
      mem_w_d   = bus.v_we;
      tag1_d    = '{valid: !bus.v_we, port: PORT_VDC};
      rr_last_d = PORT_VDC;
    end else if (c_ack) begin
      mem_a_d   = bus.c_addr;
      mem_o_d   = bus.c_wdata;
      mem_w_d   = bus.c_we;
      tag1_d    = '{valid: !bus.c_we, port: PORT_CPU};
      rr_last_d = PORT_CPU;
    end

    // The burst only counts scan grants that actually held someone off.
    if (v_ack || c_ack || !vc_any) begin
      burst_d = '0;
    end else if (s_ack && (burst_q != BW'(SCAN_BURST))) begin
      burst_d = burst_q + BW'(1);
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      mem_a_q   <= '0;
      mem_o_q   <= '0;
      mem_w_q   <= 1'b0;
      tag1_q    <= '{valid: 1'b0, port: PORT_SCAN};
      tag2_q    <= '{valid: 1'b0, port: PORT_SCAN};
      burst_q   <= '0;
      rr_last_q <= PORT_CPU;
    end else begin
      mem_a_q   <= mem_a_d;
      mem_o_q   <= mem_o_d;
      mem_w_q   <= mem_w_d;
      tag1_q    <= tag1_d;
      tag2_q    <= tag2_d;
      burst_q   <= burst_d;
      rr_last_q <= rr_last_d;
    end
  end

  vram_wait_cnt #(.MAX(MAX_WAIT)) u_v_wait (
    .clock   (clock),
    .reset_n (reset_n),
    .inc     (bus.v_req & !v_ack),
    .clr     (v_ack | !bus.v_req),
    .sat     (v_sat)
  );

  vram_wait_cnt #(.MAX(MAX_WAIT)) u_c_wait (
    .clock   (clock),
    .reset_n (reset_n),
    .inc     (bus.c_req & !c_ack),
    .clr     (c_ack | !bus.c_req),
    .sat     (c_sat)
  );

  assign bus.s_ack    = s_ack;
  assign bus.v_ack    = v_ack;
  assign bus.c_ack    = c_ack;
  assign bus.s_rvalid = tag2_q.valid && (tag2_q.port == PORT_SCAN);
  assign bus.v_rvalid = tag2_q.valid && (tag2_q.port == PORT_VDC);
  assign bus.c_rvalid = tag2_q.valid && (tag2_q.port == PORT_CPU);
  assign bus.rdata    = bus.mem_i;
  assign bus.mem_a    = mem_a_q;
  assign bus.mem_o    = mem_o_q;
  assign bus.mem_w    = mem_w_q;
  assign dbg_rr_last  = rr_last_q;

endmodule

// File: tb/tb_vram_arbiter.sv
// Directed testbench for vram_arbiter with a synchronous RAM model.
module tb_vram_arbiter;
  import vram_pkg::*;

  localparam int G_N = 0;
  localparam int G_S = 1;
  localparam int G_V = 2;
  localparam int G_C = 3;
  localparam int G_X = 7;

  logic        clock;
  logic        reset_n;
  port_e       dbg_rr_last;
  logic        pre_we;
  logic [17:0] pre_addr;
  logic [7:0]  pre_data;
  logic [7:0]  ram [0:262143];
  logic [7:0]  exp_q[$];

  int n_checks;
  int n_fail;

  vram_arbiter_if #(.AW(18), .DW(8)) bus ();

  vram_arbiter dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .bus         (bus),
    .dbg_rr_last (dbg_rr_last)
  );

  // ---------------- clock / reset ----------------
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Sync RAM: read data appears one cycle after the address.
  always @(posedge clock) begin
    if (pre_we) begin
      ram[pre_addr] <= pre_data;
    end else if (bus.mem_w) begin
      ram[bus.mem_a] <= bus.mem_o;
    end
    bus.mem_i <= ram[bus.mem_a];
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks ----------------
  task automatic idle_inputs();
    bus.s_req = 1'b0; bus.s_addr = '0;
    bus.v_req = 1'b0; bus.v_we = 1'b0; bus.v_addr = '0; bus.v_wdata = '0;
    bus.c_req = 1'b0; bus.c_we = 1'b0; bus.c_addr = '0; bus.c_wdata = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    pre_we  = 1'b0;
    reset_n = 1'b0;
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
  endtask

  task automatic preload(input logic [17:0] a, input logic [7:0] d);
    @(negedge clock);
    pre_we = 1'b1; pre_addr = a; pre_data = d;
    @(negedge clock);
    pre_we = 1'b0;
  endtask

  function automatic int grant_code();
    int n;
    n = int'(bus.s_ack) + int'(bus.v_ack) + int'(bus.c_ack);
    if (n > 1)       return G_X;
    if (bus.s_ack)   return G_S;
    if (bus.v_ack)   return G_V;
    if (bus.c_ack)   return G_C;
    return G_N;
  endfunction

  // ---------------- tests ----------------
  task automatic test_reset();
    do_reset();
    @(negedge clock);
    bus.v_req = 1'b1; bus.v_we = 1'b1; bus.v_addr = 18'h2ABCD; bus.v_wdata = 8'h77;
    #1;
    n_checks++;
    if (bus.v_ack !== 1'b1) begin n_fail++; $display("FAIL reset_pre_ack: got %b want 1", bus.v_ack); end
    @(negedge clock);
    bus.v_req = 1'b0;
    #1;
    n_checks++;
    if ({bus.mem_w, bus.mem_a, bus.mem_o} !== {1'b1, 18'h2ABCD, 8'h77}) begin
      n_fail++; $display("FAIL reset_pre_issue: got w=%b a=%h o=%h want w=1 a=2abcd o=77", bus.mem_w, bus.mem_a, bus.mem_o);
    end
    reset_n = 1'b0;
    #1;
    n_checks++;
    if ({bus.mem_w, bus.mem_a, bus.mem_o} !== '0) begin
      n_fail++; $display("FAIL reset_mem: got w=%b a=%h o=%h want all 0", bus.mem_w, bus.mem_a, bus.mem_o);
    end
    n_checks++;
    if ({bus.s_rvalid, bus.v_rvalid, bus.c_rvalid} !== 3'b000) begin
      n_fail++; $display("FAIL reset_rvalid: got %b want 000", {bus.s_rvalid, bus.v_rvalid, bus.c_rvalid});
    end
    n_checks++;
    if (dbg_rr_last !== PORT_CPU) begin
      n_fail++; $display("FAIL reset_rr_last: got %0d want %0d", dbg_rr_last, PORT_CPU);
    end
    @(negedge clock);
    reset_n = 1'b1;
  endtask

  task automatic test_single_read();
    do_reset();
    preload(18'h00123, 8'h5A);
    bus.c_req = 1'b1; bus.c_we = 1'b0; bus.c_addr = 18'h00123;
    #1;
    n_checks++;
    if (grant_code() !== G_C) begin n_fail++; $display("FAIL read_ack: got grant %0d want %0d", grant_code(), G_C); end
    @(negedge clock);
    bus.c_req = 1'b0;
    #1;
    n_checks++;
    if ({bus.mem_a, bus.mem_w, bus.c_rvalid} !== {18'h00123, 1'b0, 1'b0}) begin
      n_fail++; $display("FAIL read_issue: got a=%h w=%b rv=%b want a=00123 w=0 rv=0", bus.mem_a, bus.mem_w, bus.c_rvalid);
    end
    @(negedge clock);
    #1;
    n_checks++;
    if ({bus.c_rvalid, bus.v_rvalid, bus.s_rvalid, bus.rdata} !== {3'b100, 8'h5A}) begin
      n_fail++; $display("FAIL read_return: got c/v/s=%b%b%b rdata=%h want 100 5a", bus.c_rvalid, bus.v_rvalid, bus.s_rvalid, bus.rdata);
    end
    @(negedge clock);
    #1;
    n_checks++;
    if (bus.c_rvalid !== 1'b0) begin n_fail++; $display("FAIL read_one_shot: got c_rvalid=%b want 0", bus.c_rvalid); end
  endtask

  task automatic test_reset_mid_read();
    logic seen;
    seen = 1'b0;
    do_reset();
    @(negedge clock);
    bus.c_req = 1'b1; bus.c_we = 1'b0; bus.c_addr = 18'h00123;
    #1;
    n_checks++;
    if (bus.c_ack !== 1'b1) begin n_fail++; $display("FAIL midreset_ack: got %b want 1", bus.c_ack); end
    @(negedge clock);
    bus.c_req = 1'b0;
    reset_n = 1'b0;
    #1;
    n_checks++;
    if (bus.mem_w !== 1'b0) begin n_fail++; $display("FAIL midreset_mem_w: got %b want 0", bus.mem_w); end
    @(negedge clock);
    reset_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      if (bus.c_rvalid !== 1'b0) seen = 1'b1;
      @(negedge clock);
    end
    n_checks++;
    if (seen !== 1'b0) begin n_fail++; $display("FAIL midreset_rvalid: got c_rvalid seen=%b want 0", seen); end
  endtask

  task automatic test_scan_burst();
    int exp_hist[0:14];
    int obs;
    int run;
    int max_run;
    run = 0; max_run = 0;
    do_reset();
    @(negedge clock);
    bus.s_req = 1'b1; bus.s_addr = 18'h00040;
    bus.v_req = 1'b1; bus.v_we = 1'b0; bus.v_addr = 18'h00080;
    for (int i = 0; i < 15; i++) begin
      #1;
      exp_hist[i] = ((i % 5) == 4) ? G_V : G_S;
      obs = grant_code();
      n_checks++;
      if (obs !== exp_hist[i]) begin n_fail++; $display("FAIL scan_grant[%0d]: got %0d want %0d", i, obs, exp_hist[i]); end
      if (i >= 2) begin
        n_checks++;
        if ({bus.s_rvalid, bus.v_rvalid} !== {exp_hist[i-2] == G_S, exp_hist[i-2] == G_V}) begin
          n_fail++; $display("FAIL scan_rvalid[%0d]: got s=%b v=%b want s=%b v=%b", i, bus.s_rvalid, bus.v_rvalid,
                             exp_hist[i-2] == G_S, exp_hist[i-2] == G_V);
        end
      end
      run = bus.v_ack ? 0 : run + 1;
      if (run > max_run) max_run = run;
      @(negedge clock);
    end
    n_checks++;
    if (max_run > 4) begin n_fail++; $display("FAIL scan_v_wait: got %0d cycles want <= 4", max_run); end
    idle_inputs();
    repeat (3) @(negedge clock);
  endtask

  task automatic test_round_robin();
    int obs;
    do_reset();
    @(negedge clock);
    bus.v_req = 1'b1; bus.v_addr = 18'h00011;
    bus.c_req = 1'b1; bus.c_addr = 18'h00022;
    for (int i = 0; i < 8; i++) begin
      #1;
      obs = grant_code();
      n_checks++;
      if (obs !== (((i % 2) == 0) ? G_V : G_C)) begin
        n_fail++; $display("FAIL rr_grant[%0d]: got %0d want %0d", i, obs, ((i % 2) == 0) ? G_V : G_C);
      end
      @(negedge clock);
    end
    #1;
    n_checks++;
    if (dbg_rr_last !== PORT_CPU) begin n_fail++; $display("FAIL rr_last_after: got %0d want %0d", dbg_rr_last, PORT_CPU); end
    idle_inputs();
    repeat (3) @(negedge clock);
  endtask

  task automatic test_wait_priority();
    int exp_seq[0:19];
    int obs;
    logic v_clear;
    exp_seq = '{G_S, G_S, G_S, G_S, G_C, G_S, G_S, G_S, G_S, G_V,
                G_S, G_S, G_S, G_S, G_C, G_S, G_S, G_S, G_S, G_V};
    v_clear = 1'b0;
    do_reset();
    bus.s_addr = 18'h00100; bus.c_addr = 18'h00200; bus.v_addr = 18'h00300;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      bus.s_req = 1'b1;
      bus.c_req = 1'b1;
      if (v_clear) begin bus.v_req = 1'b0; v_clear = 1'b0; end
      if (i == 9 || i == 14) bus.v_req = 1'b1;
      #1;
      obs = grant_code();
      n_checks++;
      if (obs !== exp_seq[i]) begin n_fail++; $display("FAIL wait_grant[%0d]: got %0d want %0d", i, obs, exp_seq[i]); end
      if (bus.v_ack) v_clear = 1'b1;
    end
    @(negedge clock);
    idle_inputs();
    repeat (3) @(negedge clock);
  endtask

  task automatic test_back_to_back();
    int exp_g[0:8];
    logic exp_rv[0:8];
    int obs;
    exp_g  = '{G_V, G_C, G_C, G_V, G_C, G_N, G_N, G_N, G_N};
    exp_rv = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    exp_q.delete();
    do_reset();
    for (int i = 0; i < 9; i++) begin
      @(negedge clock);
      case (i)
        0: begin
          bus.v_req = 1'b1; bus.v_we = 1'b1; bus.v_addr = 18'h20010; bus.v_wdata = 8'hAA;
          bus.c_req = 1'b1; bus.c_we = 1'b0; bus.c_addr = 18'h20010;
        end
        1: bus.v_req = 1'b0;
        3: begin
          bus.c_req = 1'b0;
          bus.v_req = 1'b1; bus.v_we = 1'b1; bus.v_addr = 18'h20010; bus.v_wdata = 8'h55;
        end
        4: begin bus.v_req = 1'b0; bus.c_req = 1'b1; end
        5: bus.c_req = 1'b0;
        default: ;
      endcase
      #1;
      obs = grant_code();
      n_checks++;
      if (obs !== exp_g[i]) begin n_fail++; $display("FAIL b2b_grant[%0d]: got %0d want %0d", i, obs, exp_g[i]); end
      if (i == 1 || i == 2) exp_q.push_back(8'hAA);
      if (i == 4) exp_q.push_back(8'h55);
      n_checks++;
      if ({bus.c_rvalid, bus.v_rvalid} !== {exp_rv[i], 1'b0}) begin
        n_fail++; $display("FAIL b2b_rvalid[%0d]: got c=%b v=%b want c=%b v=0", i, bus.c_rvalid, bus.v_rvalid, exp_rv[i]);
      end
      if (bus.c_rvalid === 1'b1 && exp_q.size() > 0) begin
        n_checks++;
        if (bus.rdata !== exp_q[0]) begin n_fail++; $display("FAIL b2b_rdata[%0d]: got %h want %h", i, bus.rdata, exp_q[0]); end
        void'(exp_q.pop_front());
      end
    end
    n_checks++;
    if (exp_q.size() != 0) begin n_fail++; $display("FAIL b2b_drain: got %0d pending want 0", exp_q.size()); end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    n_checks = 0;
    n_fail   = 0;
    idle_inputs();
    pre_we   = 1'b0;
    pre_addr = '0;
    pre_data = '0;
    reset_n  = 1'b0;
    test_reset();
    test_single_read();
    test_reset_mid_read();
    test_scan_burst();
    test_round_robin();
    test_wait_priority();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
